// File: rtl/vending_pkg.sv
// Shared vending definitions: coin denominations, one-hot indices and the
// change dispenser state encoding.
package vending_pkg;

    localparam int AMT_W_DEFAULT = 8;

    localparam int unsigned DENOM_1  = 1;
    localparam int unsigned DENOM_5  = 5;
    localparam int unsigned DENOM_10 = 10;
    localparam int unsigned DENOM_20 = 20;
    localparam int unsigned DENOM_50 = 50;

    // Bit positions inside the one-hot denomination vector (MSB = 50).
    localparam int IDX_1  = 0;
    localparam int IDX_5  = 1;
    localparam int IDX_10 = 2;
    localparam int IDX_20 = 3;
    localparam int IDX_50 = 4;

    typedef enum logic [2:0] {
        CD_IDLE     = 3'd0,
        CD_SELECT   = 3'd1,
        CD_WAIT_ACK = 3'd2,
        CD_DONE     = 3'd3,
        CD_FAULT    = 3'd4
    } cd_state_e;

    function automatic int unsigned denom_value(input logic [4:0] onehot);
        int unsigned v;
        v = 0;
        if (onehot[IDX_50]) v = DENOM_50;
        if (onehot[IDX_20]) v = DENOM_20;
        if (onehot[IDX_10]) v = DENOM_10;
        if (onehot[IDX_5])  v = DENOM_5;
        if (onehot[IDX_1])  v = DENOM_1;
        return v;
    endfunction

endpackage

// File: rtl/change_dispenser_denom_select.sv
// Combinational greedy picker: largest denomination not exceeding the amount,
// as a one-hot vector plus its value. Zero in gives zero out.
module denom_select
    import vending_pkg::*;
#(
    parameter int AMT_W = AMT_W_DEFAULT
) (
    input  logic [AMT_W-1:0] remaining_i,
    output logic [4:0]       denom_o,
    output logic [AMT_W-1:0] value_o
);

    logic [31:0] rem_w;

    always_comb begin
        rem_w   = 32'(remaining_i);
        denom_o = '0;
        value_o = '0;
        if (rem_w >= DENOM_50) begin
            denom_o[IDX_50] = 1'b1;
            value_o         = AMT_W'(DENOM_50);
        end else if (rem_w >= DENOM_20) begin
            denom_o[IDX_20] = 1'b1;
            value_o         = AMT_W'(DENOM_20);
        end else if (rem_w >= DENOM_10) begin
            denom_o[IDX_10] = 1'b1;
            value_o         = AMT_W'(DENOM_10);
        end else if (rem_w >= DENOM_5) begin
            denom_o[IDX_5] = 1'b1;
            value_o        = AMT_W'(DENOM_5);
        end else if (rem_w >= DENOM_1) begin
            denom_o[IDX_1] = 1'b1;
            value_o        = AMT_W'(DENOM_1);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount one denomination per disp_valid/disp_ack handshake.
// Define CHANGE_TALLY_EN to add the per-denomination issue counters and tally port.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int AMT_W   = AMT_W_DEFAULT,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               start,
    input  logic [AMT_W-1:0]   change_amt,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               fault,
    output logic               disp_valid,
    output logic [4:0]         disp_denom,
    input  logic               disp_ack,
    output logic [AMT_W-1:0]   remaining,
`ifdef CHANGE_TALLY_EN
    output logic [5*AMT_W-1:0] tally,
`endif
    output logic [2:0]         dbg_state
);

    localparam int TMO_W = $clog2(TIMEOUT);

    // Handshake: an item transfers on any rising edge where disp_valid and
    // disp_ack are both high; disp_denom is held stable while disp_valid is high.
    cd_state_e         state_q, state_d;
    logic [AMT_W-1:0]  remaining_q;
    logic [4:0]        disp_denom_q;
    logic              disp_valid_q;
    logic              busy_q;
    logic              done_q;
    logic              fault_q;
    logic [TMO_W-1:0]  tmo_q;

    logic [4:0]        sel_denom;
    logic [AMT_W-1:0]  sel_value;
    logic              start_ok;
    logic              ack_take;
    logic              tmo_hit;
    logic [AMT_W-1:0]  rem_after;

    denom_select #(.AMT_W(AMT_W)) u_denom_select (
        .remaining_i (remaining_q),
        .denom_o     (sel_denom),
        .value_o     (sel_value)
    );

    always_comb begin
        start_ok  = start && (state_q == CD_IDLE || state_q == CD_FAULT);
        ack_take  = (state_q == CD_WAIT_ACK) && disp_ack;
        tmo_hit   = (state_q == CD_WAIT_ACK) && !disp_ack
                    && (tmo_q == TMO_W'(TIMEOUT - 1));
        rem_after = remaining_q - AMT_W'(denom_value(disp_denom_q));

        state_d = state_q;
        case (state_q)
            CD_IDLE: begin
                if (start_ok) state_d = (change_amt != '0) ? CD_SELECT : CD_DONE;
            end
            CD_FAULT: begin
                if (start_ok)   state_d = (change_amt != '0) ? CD_SELECT : CD_DONE;
                else if (abort) state_d = CD_IDLE;
            end
            CD_SELECT: begin
                state_d = abort ? CD_IDLE : CD_WAIT_ACK;
            end
            CD_WAIT_ACK: begin
                // An ack in the abort cycle still counts; abort only decides where we go.
                if (ack_take) begin
                    if (abort)                state_d = CD_IDLE;
                    else if (rem_after != '0) state_d = CD_SELECT;
                    else                      state_d = CD_DONE;
                end else if (abort) begin
                    state_d = CD_IDLE;
                end else if (tmo_hit) begin
                    state_d = CD_FAULT;
                end
            end
            CD_DONE: begin
                state_d = CD_IDLE;
            end
            default: state_d = CD_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= CD_IDLE;
            remaining_q  <= '0;
            disp_denom_q <= '0;
            disp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= (state_d == CD_SELECT) || (state_d == CD_WAIT_ACK)
                            || (state_d == CD_DONE);
            fault_q      <= (state_d == CD_FAULT);
            disp_valid_q <= (state_d == CD_WAIT_ACK);
            // done follows the DONE state by one cycle so an abort there can cancel it.
            done_q       <= (state_q == CD_DONE) && !abort;

            if (state_q == CD_SELECT && state_d == CD_WAIT_ACK)
                disp_denom_q <= sel_denom;
            else if (state_d != CD_WAIT_ACK)
                disp_denom_q <= '0;

            if (start_ok)
                remaining_q <= change_amt;
            else if (ack_take)
                remaining_q <= rem_after;

            if (state_q == CD_WAIT_ACK && state_d == CD_WAIT_ACK)
                tmo_q <= tmo_q + TMO_W'(1);
            else
                tmo_q <= '0;
        end
    end

`ifdef CHANGE_TALLY_EN
    logic [AMT_W-1:0] tally_q [5];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < 5; i++) tally_q[i] <= '0;
        end else if (start_ok) begin
            for (int i = 0; i < 5; i++) tally_q[i] <= '0;
        end else if (ack_take) begin
            for (int i = 0; i < 5; i++) begin
                if (disp_denom_q[i] && (tally_q[i] != {AMT_W{1'b1}}))
                    tally_q[i] <= tally_q[i] + AMT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < 5; g++) begin : g_tally
        assign tally[g*AMT_W +: AMT_W] = tally_q[g];
    end
`endif

    assign busy       = busy_q;
    assign done       = done_q;
    assign fault      = fault_q;
    assign disp_valid = disp_valid_q;
    assign disp_denom = disp_denom_q;
    assign remaining  = remaining_q;
    assign dbg_state  = state_q;

endmodule
